// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state encoding and the width of the shared adder slice.
package serial_adder_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_four_bit_adder.sv
// Four-bit ripple-carry adder slice shared by every nibble step of the
// serial sequencer.
module four_bit_adder
    import serial_adder_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[SLICE_W];
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial add/subtract controller: one shared 4-bit slice processes
// the operands LSB nibble first, and the result leaves through valid/ready.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int NIB   = WIDTH / SLICE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends on valid, and the producer holds
    // valid and data stable until the transfer.

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q, b_eff_q, sum_q;
    logic               carry_q, carry_out_q, overflow_q;
    logic               accept, step, last;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic               slice_c;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign slice_a = a_q[SLICE_W*idx_q +: SLICE_W];
    assign slice_b = b_eff_q[SLICE_W*idx_q +: SLICE_W];

    four_bit_adder u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    // Subtraction is a + ~b + 1, so the inversion and the forced carry-in
    // are applied once at acceptance and the slice only ever adds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            a_q         <= '0;
            b_eff_q     <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= op_a;
                b_eff_q <= sub ? ~op_b : op_b;
                carry_q <= sub ? 1'b1 : c_in;
                idx_q   <= '0;
            end
            if (step) begin
                sum_q[SLICE_W*idx_q +: SLICE_W] <= slice_s;
                carry_q <= slice_c;
                idx_q   <= last ? '0 : idx_q + 1'b1;
                if (last) begin
                    carry_out_q <= slice_c;
                    overflow_q  <= (a_q[WIDTH-1] == b_eff_q[WIDTH-1]) &&
                                   (slice_s[SLICE_W-1] != a_q[WIDTH-1]);
                end
            end
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed corner cases, backpressure,
// mid-run reset and random operations against an arithmetic reference model.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic [1:0]   dbg_state;

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard entries are {overflow, carry_out, sum}.
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_exp;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin, input logic is_sub);
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           sa, sb, sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (is_sub) begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            r  = a + b + W'(cin);
            c  = (int'(a) + int'(b) + int'(cin)) > ((1 << W) - 1);
            sr = sa + sb + int'(cin);
        end
        v = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
        return {v, c, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic is_sub);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        c_in     = cin;
        sub      = is_sub;
        exp_q.push_back(ref_model(a, b, cin, is_sub));
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("state_run", 32'(dbg_state), 32'(S_RUN));
        chk("in_ready_in_run", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_result();
        int lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(NIB));
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_exp_avail"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) last_exp = exp_q.pop_front();
        chk({tag, "_sum"}, 32'(sum), 32'(last_exp[W-1:0]));
        chk({tag, "_carry"}, 32'(carry_out), 32'(last_exp[W]));
        chk({tag, "_ovf"}, 32'(overflow), 32'(last_exp[W+1]));
    endtask

    task automatic consume(input int hold);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_result", 32'({overflow, carry_out, sum}), 32'(last_exp));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_state", 32'(dbg_state), 32'(S_DONE));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_retained", 32'({overflow, carry_out, sum}), 32'(last_exp));
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic is_sub, input int hold);
        start_op(a, b, cin, is_sub);
        wait_result();
        check_result(tag);
        consume(hold);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        last_exp  = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        do_op("add_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
        do_op("add_ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op("add_ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 2);
        do_op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        do_op("sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        do_op("add_cin",     16'h00FF, 16'h0000, 1'b1, 1'b0, 0);

        // Backpressure with a pending request held on the input side.
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_result();
        check_result("bp_first");
        in_valid = 1'b1;
        op_a     = 16'hABCD;
        op_b     = 16'h1234;
        c_in     = 1'b0;
        sub      = 1'b1;
        consume(5);
        exp_q.push_back(ref_model(16'hABCD, 16'h1234, 1'b0, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accepted_busy", 32'(busy), 32'd1);
        chk("bp_accepted_state", 32'(dbg_state), 32'(S_RUN));
        wait_result();
        check_result("bp_second");
        consume(0);

        // Reset while the third nibble is about to be processed.
        start_op(16'h9ABC, 16'h1357, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_carry", 32'(carry_out), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        do_op("after_rst", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            do_op("rand",
                  W'($urandom_range(0, (1 << W) - 1)),
                  W'($urandom_range(0, (1 << W) - 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
